lcd_mem_viewer: RTL and testbench
=================================

// Module: lcd_mem_viewer
// PURPOSE
//  Debug display stage downstream of the data memory (stage four/five). On each trigger press it reads one
//  32-bit word from data memory and shows it on the board's HD44780 16x2 LCD in uppercase hex:
//  line 1 = address (8 chars), line 2 = data (8 chars). It shares the memory read port with the core, so it
//  is only triggered while the core is halted.
// PARAMETERS
//  ADDR_WIDTH     32        data memory address width
//  DATA_WIDTH     32        data memory word width (fixed at 32 for hex display)
//  BASE_ADDR      0         first address shown after reset
//  ADDR_STEP      4         address increment after each displayed word
//  MEM_LATENCY    1         cycles from data_mem_rd_en_out to valid mem_data_in (1..3)
//  INIT_WAIT_CYC  750000    power-up wait before the first LCD command (15 ms at 50 MHz)
//  EN_PULSE_CYC   25        lcd_en_out high time per byte
//  CMD_WAIT_CYC   2500      post-byte wait for every byte except clear
//  CLR_WAIT_CYC   100000    post-byte wait after the clear command (0x01)
//  DEBOUNCE_CYC   1000000   read_in stable time (only used with LCD_DEBOUNCE_EN)
// PORTS
//  clk                 in   1           system clock
//  rst                 in   1           synchronous reset, active-low
//  read_in             in   1           display trigger, active-high (key)
//  mem_data_in         in   DATA_WIDTH  data memory read data
//  addr_out            out  ADDR_WIDTH  data memory address
//  data_mem_rd_en_out  out  1           data memory read enable, one-cycle pulse
//  lcd_data_out        out  8           LCD data bus
//  lcd_on_out          out  1           LCD power
//  lcd_blon_out        out  1           LCD backlight
//  lcd_rw_out          out  1           LCD R/W, tied 0 (write only)
//  lcd_en_out          out  1           LCD enable strobe
//  lcd_rs_out          out  1           0 = command, 1 = data
//  busy_out            out  1           high from reset until IDLE, and during each display update
// BEHAVIOUR
//  Reset (rst==0 at a clk edge):
//   - addr_out = BASE_ADDR; all other outputs 0 except busy_out = 1.
//   - State goes to INIT_WAIT. Reset mid-transfer aborts the transfer and reruns full init.
//  After reset: lcd_on_out = lcd_blon_out = 1; lcd_rw_out is always 0.
//  Byte transfer (sub-module):
//   - 1 setup cycle with rs/data driven, then en high for EN_PULSE_CYC, then en low.
//   - Then wait CMD_WAIT_CYC, or CLR_WAIT_CYC if the byte is the command 0x01.
//   - data/rs are held until the wait ends.
//  FSM:
//   - INIT_WAIT: wait INIT_WAIT_CYC.
//   - INIT_CMD: send commands 0x38, 0x0C, 0x01, 0x06 in that order.
//   - IDLE: busy_out = 0. A trigger edge goes to MEM_REQ.
//   - MEM_REQ: one cycle, data_mem_rd_en_out = 1.
//   - MEM_WAIT: MEM_LATENCY cycles, then latch mem_data_in.
//   - LINE1: command 0x80, then 8 address chars, MSB nibble first.
//   - LINE2: command 0xC0, then 8 data chars, MSB nibble first.
//   - DONE: addr_out += ADDR_STEP modulo 2^ADDR_WIDTH (wraps silently), then go to IDLE.
//  addr_out holds the shown address from MEM_REQ until DONE.
//  Hex to ASCII: nibble 0-9 -> 0x30+n; nibble A-F -> 0x41+(n-10).
//  Triggers arriving while busy_out = 1 are dropped, not queued. A held key gives exactly one update.
//  Trigger edge = rising edge of the (optionally debounced) read_in, registered through 2 flops for sync.
// CONFIGURATION
//  LCD_DEBOUNCE_EN defined:
//   - read_in must be stable for DEBOUNCE_CYC cycles before its filtered level changes.
//   - Edge detection runs on the filtered level.
//  Not defined: edge detection runs directly on the synchronised read_in; no filter logic is built.
// STRUCTURE
//  Shared include lcd_pkg.vh holds:
//   - LCD command constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, LINE1 0x80, LINE2 0xC0)
//   - FSM state encodings
//   - hex_to_ascii function.
//  Sub-module lcd_byte_writer: start/rs/byte in, done pulse out; owns en/setup/wait timing.
// TESTING (bench uses small timing params, e.g. INIT_WAIT_CYC=20, CMD_WAIT_CYC=5, CLR_WAIT_CYC=10)
//  1 Reset release -> exactly 4 en pulses with rs=0, data 0x38,0x0C,0x01,0x06 in order; then busy_out=0.
//  2 Memory word 0x0 = 0xDEADBEEF, one trigger:
//     -> rd_en pulse with addr_out=0x0
//     -> bytes 0x80,"00000000",0xC0,"DEADBEEF" (rs=1 for chars)
//     -> final addr_out=0x4.
//  3 Second trigger, word 0x4 = 0x0000A5C3 -> line1 "00000004", line2 "0000A5C3"; addr_out ends 0x8.
//  4 BASE_ADDR=0xFFFFFFFC, one trigger -> displays "FFFFFFFC", then addr_out wraps to 0x00000000.
//  5 Trigger held high during update plus a second pulse mid-LINE1
//     -> one update only, one rd_en pulse total.
//  6 rst low during LINE2 -> next cycle all outputs at reset values;
//     full init sequence repeats; addr_out=BASE_ADDR.
//  7 With LCD_DEBOUNCE_EN, DEBOUNCE_CYC=8:
//     -> a 5-cycle glitch on read_in causes no update
//     -> a 12-cycle press causes one update.

Source files
------------

// File: rtl/lcd_mem_viewer_pkg.sv
// lcd_mem_viewer_pkg
// Shared definitions for the LCD memory viewer:
//   - HD44780 command bytes used by the init and line-select sequences
//   - top-level FSM state encoding and byte-writer phase encoding
//   - hex/character helpers used to build the displayed bytes
// No ports (package).
package lcd_mem_viewer_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display (slow command)
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] LCD_LINE1    = 8'h80;  // DDRAM address of line 1
  localparam logic [7:0] LCD_LINE2    = 8'hC0;  // DDRAM address of line 2

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_CMD,
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_LINE1,
    S_LINE2,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    BW_IDLE,
    BW_SETUP,
    BW_PULSE,
    BW_WAIT
  } bw_phase_t;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  // Power-up command sequence, in order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

  // pos 1 selects the most significant nibble, pos 8 the least.
  function automatic logic [3:0] nibble_at(input logic [31:0] w, input logic [3:0] pos);
    case (pos)
      4'd1:    return w[31:28];
      4'd2:    return w[27:24];
      4'd3:    return w[23:20];
      4'd4:    return w[19:16];
      4'd5:    return w[15:12];
      4'd6:    return w[11:8];
      4'd7:    return w[7:4];
      4'd8:    return w[3:0];
      default: return 4'h0;
    endcase
  endfunction

  // Byte idx of a display line: idx 0 is the line-select command, 1..8 the hex chars.
  function automatic logic [7:0] line_byte(input logic [7:0] cmd, input logic [31:0] w,
                                           input logic [3:0] idx);
    if (idx == 4'd0) return cmd;
    else             return hex_to_ascii(nibble_at(w, idx));
  endfunction

endpackage

// File: rtl/lcd_mem_viewer_byte_writer.sv
// lcd_mem_viewer_byte_writer
// Sends one byte to an HD44780 over the 8-bit bus: one setup cycle with rs/data
// driven, en high for EN_PULSE_CYC cycles, then a post-byte wait (CLR_WAIT_CYC
// after the clear command, CMD_WAIT_CYC otherwise). rs/data stay stable until the
// wait ends; done pulses for one cycle when the next byte may be started.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   start          one-cycle request, accepted only while idle
//   rs, byte_in    register select and byte to send (sampled with start)
//   lcd_data/rs/en LCD bus outputs (registered)
//   done           one-cycle pulse at the end of the post-byte wait
module lcd_mem_viewer_byte_writer
  import lcd_mem_viewer_pkg::*;
#(
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] byte_in,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       done
);

  bw_phase_t   phase;
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase    <= BW_IDLE;
      cnt      <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        BW_IDLE: begin
          if (start) begin
            lcd_data <= byte_in;
            lcd_rs   <= rs;
            phase    <= BW_SETUP;
          end
        end
        BW_SETUP: begin
          lcd_en <= 1'b1;
          cnt    <= 32'(EN_PULSE_CYC - 1);
          phase  <= BW_PULSE;
        end
        BW_PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            // Clear needs the long wait; everything else, including data 0x01, is fast.
            cnt    <= (!lcd_rs && lcd_data == LCD_CLEAR) ? 32'(CLR_WAIT_CYC - 1)
                                                         : 32'(CMD_WAIT_CYC - 1);
            phase  <= BW_WAIT;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        BW_WAIT: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            phase <= BW_IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: phase <= BW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_mem_viewer.sv
// lcd_mem_viewer
// Debug display stage: on each trigger press reads one 32-bit word from data
// memory and shows it on a 16x2 HD44780 LCD in uppercase hex (line 1 = address,
// line 2 = data). Only triggered while the core is halted (shared read port).
// Optional macro LCD_DEBOUNCE_EN: read_in must be stable for DEBOUNCE_CYC cycles
// before its filtered level changes; without it no filter logic is built.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   read_in             display trigger (key), active-high
//   mem_data_in         data memory read data
//   addr_out            data memory address / address being shown
//   data_mem_rd_en_out  one-cycle read enable
//   lcd_data_out, lcd_rs_out, lcd_en_out, lcd_rw_out, lcd_on_out, lcd_blon_out  LCD pins
//   busy_out            high from reset until IDLE and during every update
//
// state      | meaning
// INIT_WAIT  | power-up delay before the first LCD command
// INIT_CMD   | send function set, display on, clear, entry mode
// IDLE       | waiting for a trigger edge
// MEM_REQ    | read enable pulse with addr_out driven
// MEM_WAIT   | wait MEM_LATENCY cycles, then capture the word
// LINE1      | line-1 select, then 8 address chars
// LINE2      | line-2 select, then 8 data chars
// DONE       | advance addr_out, return to IDLE
module lcd_mem_viewer
  import lcd_mem_viewer_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    ADDR_STEP     = 4,
  parameter int                    MEM_LATENCY   = 1,
  parameter int                    INIT_WAIT_CYC = 750000,
  parameter int                    EN_PULSE_CYC  = 25,
  parameter int                    CMD_WAIT_CYC  = 2500,
  parameter int                    CLR_WAIT_CYC  = 100000
`ifdef LCD_DEBOUNCE_EN
  ,
  parameter int                    DEBOUNCE_CYC  = 1000000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  data_mem_rd_en_out,
  output logic [7:0]            lcd_data_out,
  output logic                  lcd_on_out,
  output logic                  lcd_blon_out,
  output logic                  lcd_rw_out,
  output logic                  lcd_en_out,
  output logic                  lcd_rs_out,
  output logic                  busy_out
);

  // Trigger path: 2-flop synchroniser, optional filter, rising-edge detect.
  logic [1:0] sync_q;
  logic       trig_level;
  logic       trig_prev;
  logic       trig_edge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      trig_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], read_in};
      trig_prev <= trig_level;
    end
  end

`ifdef LCD_DEBOUNCE_EN
  logic        db_level;
  logic [31:0] db_cnt;

  // Any bounce back to the current level restarts the stability window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_level <= 1'b0;
      db_cnt   <= 32'(DEBOUNCE_CYC - 1);
    end else if (sync_q[1] == db_level) begin
      db_cnt <= 32'(DEBOUNCE_CYC - 1);
    end else if (db_cnt == '0) begin
      db_level <= sync_q[1];
      db_cnt   <= 32'(DEBOUNCE_CYC - 1);
    end else begin
      db_cnt <= db_cnt - 32'd1;
    end
  end

  assign trig_level = db_level;
`else
  assign trig_level = sync_q[1];
`endif

  assign trig_edge = trig_level & ~trig_prev;

  // Main sequencer
  state_t                state;
  logic [3:0]            idx;
  logic                  sent;
  logic [31:0]           cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_start;
  logic                  wr_rs;
  logic [7:0]            wr_byte;
  logic                  wr_done;
  logic [31:0]           addr_disp;
  logic [31:0]           data_disp;

  assign addr_disp  = 32'(addr_out);
  assign data_disp  = 32'(data_q);
  assign lcd_rw_out = 1'b0;

  // 'sent' marks a byte handed to the writer whose done pulse is still pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= S_INIT_WAIT;
      idx                <= '0;
      sent               <= 1'b0;
      cnt                <= 32'(INIT_WAIT_CYC - 1);
      data_q             <= '0;
      wr_start           <= 1'b0;
      wr_rs              <= 1'b0;
      wr_byte            <= '0;
      addr_out           <= BASE_ADDR;
      data_mem_rd_en_out <= 1'b0;
      lcd_on_out         <= 1'b0;
      lcd_blon_out       <= 1'b0;
      busy_out           <= 1'b1;
    end else begin
      wr_start           <= 1'b0;
      data_mem_rd_en_out <= 1'b0;
      lcd_on_out         <= 1'b1;
      lcd_blon_out       <= 1'b1;
      case (state)
        S_INIT_WAIT: begin
          if (cnt == '0) begin
            state <= S_INIT_CMD;
            idx   <= '0;
            sent  <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_INIT_CMD: begin
          if (!sent) begin
            wr_start <= 1'b1;
            wr_rs    <= 1'b0;
            wr_byte  <= init_cmd(idx[1:0]);
            sent     <= 1'b1;
          end else if (wr_done) begin
            sent <= 1'b0;
            if (idx == 4'd3) begin
              state    <= S_IDLE;
              busy_out <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_IDLE: begin
          if (trig_edge) begin
            state              <= S_MEM_REQ;
            data_mem_rd_en_out <= 1'b1;
            busy_out           <= 1'b1;
          end
        end
        S_MEM_REQ: begin
          state <= S_MEM_WAIT;
          cnt   <= 32'(MEM_LATENCY - 1);
        end
        S_MEM_WAIT: begin
          if (cnt == '0) begin
            data_q <= mem_data_in;
            state  <= S_LINE1;
            idx    <= '0;
            sent   <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_LINE1: begin
          if (!sent) begin
            wr_start <= 1'b1;
            wr_rs    <= (idx != 4'd0);
            wr_byte  <= line_byte(LCD_LINE1, addr_disp, idx);
            sent     <= 1'b1;
          end else if (wr_done) begin
            sent <= 1'b0;
            if (idx == 4'd8) begin
              state <= S_LINE2;
              idx   <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_LINE2: begin
          if (!sent) begin
            wr_start <= 1'b1;
            wr_rs    <= (idx != 4'd0);
            wr_byte  <= line_byte(LCD_LINE2, data_disp, idx);
            sent     <= 1'b1;
          end else if (wr_done) begin
            sent <= 1'b0;
            if (idx == 4'd8) begin
              state <= S_DONE;
              idx   <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_DONE: begin
          addr_out <= addr_out + ADDR_WIDTH'(ADDR_STEP);
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end
        default: state <= S_INIT_WAIT;
      endcase
    end
  end

  lcd_mem_viewer_byte_writer #(
    .EN_PULSE_CYC (EN_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_writer (
    .clk      (clk),
    .rst      (rst),
    .start    (wr_start),
    .rs       (wr_rs),
    .byte_in  (wr_byte),
    .lcd_data (lcd_data_out),
    .lcd_rs   (lcd_rs_out),
    .lcd_en   (lcd_en_out),
    .done     (wr_done)
  );

endmodule

// File: tb/tb_lcd_mem_viewer.sv
`timescale 1ns/1ps
module tb_lcd_mem_viewer;

  typedef logic [8:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        read1, read2;
  logic [31:0] mdata1, mdata2;
  logic [31:0] addr1, addr2;
  logic        rd1, rd2;
  logic [7:0]  lcd_data1, lcd_data2;
  logic        on1, on2, blon1, blon2, rw1, rw2, en1, en2, rs1, rs2, busy1, busy2;

  lcd_mem_viewer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_0000), .ADDR_STEP(4),
    .MEM_LATENCY(1), .INIT_WAIT_CYC(20), .EN_PULSE_CYC(3), .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(10)
`ifdef LCD_DEBOUNCE_EN
    , .DEBOUNCE_CYC(8)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .read_in(read1), .mem_data_in(mdata1), .addr_out(addr1),
    .data_mem_rd_en_out(rd1), .lcd_data_out(lcd_data1), .lcd_on_out(on1), .lcd_blon_out(blon1),
    .lcd_rw_out(rw1), .lcd_en_out(en1), .lcd_rs_out(rs1), .busy_out(busy1)
  );

  lcd_mem_viewer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'hFFFF_FFFC), .ADDR_STEP(4),
    .MEM_LATENCY(1), .INIT_WAIT_CYC(20), .EN_PULSE_CYC(3), .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(10)
`ifdef LCD_DEBOUNCE_EN
    , .DEBOUNCE_CYC(8)
`endif
  ) dut2 (
    .clk(clk), .rst(rst), .read_in(read2), .mem_data_in(mdata2), .addr_out(addr2),
    .data_mem_rd_en_out(rd2), .lcd_data_out(lcd_data2), .lcd_on_out(on2), .lcd_blon_out(blon2),
    .lcd_rw_out(rw2), .lcd_en_out(en2), .lcd_rs_out(rs2), .busy_out(busy2)
  );

  // Memory models: data valid exactly one cycle after the read enable, junk otherwise.
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] mem2 [logic [31:0]];
  always @(posedge clk) begin
    mdata1 <= rd1 ? (mem1.exists(addr1) ? mem1[addr1] : 32'h0) : 32'h0BAD_F00D;
    mdata2 <= rd2 ? (mem2.exists(addr2) ? mem2[addr2] : 32'h0) : 32'h0BAD_F00D;
  end

  // Bus monitors: record {rs,data} at each en rising edge, and each read request.
  logic [8:0]  cap1[$], cap2[$];
  logic [31:0] rda1[$], rda2[$];
  int          rdn1 = 0, rdn2 = 0;
  logic        en1_p = 1'b0, en2_p = 1'b0;
  always @(negedge clk) begin
    if (en1 && !en1_p) cap1.push_back({rs1, lcd_data1});
    if (en2 && !en2_p) cap2.push_back({rs2, lcd_data2});
    en1_p = en1;
    en2_p = en2;
    if (rd1) begin rdn1++; rda1.push_back(addr1); end
    if (rd2) begin rdn2++; rda2.push_back(addr2); end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr1 = 32'h0;
  logic [31:0] exp_addr2 = 32'hFFFF_FFFC;

  // Reference: what the LCD should receive for one displayed word.
  function automatic bq_t exp_update(input logic [31:0] a, input logic [31:0] d);
    bq_t   q;
    string hexd = "0123456789ABCDEF";
    q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 8; i++) q.push_back({1'b1, 8'(hexd[int'((a >> (28 - 4 * i)) & 32'hF)])});
    q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 8; i++) q.push_back({1'b1, 8'(hexd[int'((d >> (28 - 4 * i)) & 32'hF)])});
    return q;
  endfunction

  task automatic press(input bit sel, input int n);
    @(negedge clk);
    if (sel) read2 = 1'b1; else read1 = 1'b1;
    repeat (n) @(negedge clk);
    read1 = 1'b0;
    read2 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, output bit timeout);
    bit seen;
    seen    = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sel ? busy2 : busy1) seen = 1'b1;
      else if (seen) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; read1 = 1'b0; read2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (addr1 !== 32'h0) begin errors++; $display("FAIL rst_addr1 got %h want 00000000", addr1); end
    checks++; if (addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr2 got %h want fffffffc", addr2); end
    checks++; if ({rd1, on1, blon1, rw1, en1, rs1, busy1} !== 7'b0000001)
      begin errors++; $display("FAIL rst_ctrl1 got %b want 0000001", {rd1, on1, blon1, rw1, en1, rs1, busy1}); end
    checks++; if (lcd_data1 !== 8'h00) begin errors++; $display("FAIL rst_data1 got %h want 00", lcd_data1); end
    checks++; if ({rd2, on2, blon2, rw2, en2, rs2, busy2} !== 7'b0000001)
      begin errors++; $display("FAIL rst_ctrl2 got %b want 0000001", {rd2, on2, blon2, rw2, en2, rs2, busy2}); end
  endtask

  task automatic test_init();
    bit   to;
    int   c0;
    logic [8:0] exp_init [4];
    exp_init = '{9'h038, 9'h00C, 9'h001, 9'h006};
    c0 = cap1.size();
    @(negedge clk) rst = 1'b1;
    wait_idle(0, to);
    checks++; if (to) begin errors++; $display("FAIL init_timeout got busy want idle"); end
    checks++; if (cap1.size() - c0 != 4) begin errors++; $display("FAIL init_len got %0d want 4", cap1.size() - c0); end
    for (int i = 0; i < 4 && c0 + i < cap1.size(); i++) begin
      checks++;
      if (cap1[c0 + i] !== exp_init[i]) begin errors++; $display("FAIL init_byte[%0d] got %03h want %03h", i, cap1[c0 + i], exp_init[i]); end
    end
    checks++; if ({on1, blon1, rw1} !== 3'b110) begin errors++; $display("FAIL init_pwr got %b want 110", {on1, blon1, rw1}); end
    checks++; if (addr1 !== exp_addr1) begin errors++; $display("FAIL init_addr got %h want %h", addr1, exp_addr1); end
  endtask

  // Sequential updates: two fixed words, then random ones.
  task automatic test_update_seq();
    logic [31:0] words [5];
    logic [31:0] a;
    bq_t eq;
    bit  to;
    int  r0, c0;
    words = '{32'hDEAD_BEEF, 32'h0000_A5C3, $urandom, $urandom, $urandom};
    for (int k = 0; k < 5; k++) begin
      a = exp_addr1;
      mem1[a] = words[k];
      eq = exp_update(a, words[k]);
      r0 = rdn1; c0 = cap1.size();
      press(0, 12);
      wait_idle(0, to);
      checks++; if (to) begin errors++; $display("FAIL upd%0d_timeout got busy want idle", k); end
      checks++; if (rdn1 - r0 != 1) begin errors++; $display("FAIL upd%0d_rdcnt got %0d want 1", k, rdn1 - r0); end
      checks++; if (rda1.size() <= r0 || rda1[r0] !== a) begin errors++; $display("FAIL upd%0d_rdaddr want %h", k, a); end
      checks++; if (cap1.size() - c0 != 18) begin errors++; $display("FAIL upd%0d_len got %0d want 18", k, cap1.size() - c0); end
      for (int i = 0; i < 18 && c0 + i < cap1.size(); i++) begin
        checks++;
        if (cap1[c0 + i] !== eq[i]) begin errors++; $display("FAIL upd%0d_byte[%0d] got %03h want %03h", k, i, cap1[c0 + i], eq[i]); end
      end
      exp_addr1 = exp_addr1 + 32'd4;
      checks++; if (addr1 !== exp_addr1) begin errors++; $display("FAIL upd%0d_addr got %h want %h", k, addr1, exp_addr1); end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    bq_t eq;
    bit  to;
    int  r0, c0;
    d = $urandom;
    mem2[exp_addr2] = d;
    eq = exp_update(exp_addr2, d);
    r0 = rdn2; c0 = cap2.size();
    press(1, 12);
    wait_idle(1, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout got busy want idle"); end
    checks++; if (rdn2 - r0 != 1 || rda2.size() <= r0 || rda2[r0] !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL wrap_rd got count %0d want 1 at fffffffc", rdn2 - r0); end
    checks++; if (cap2.size() - c0 != 18) begin errors++; $display("FAIL wrap_len got %0d want 18", cap2.size() - c0); end
    for (int i = 0; i < 18 && c0 + i < cap2.size(); i++) begin
      checks++;
      if (cap2[c0 + i] !== eq[i]) begin errors++; $display("FAIL wrap_byte[%0d] got %03h want %03h", i, cap2[c0 + i], eq[i]); end
    end
    exp_addr2 = exp_addr2 + 32'd4;
    checks++; if (addr2 !== exp_addr2) begin errors++; $display("FAIL wrap_addr got %h want %h", addr2, exp_addr2); end
  endtask

  task automatic test_held_key();
    logic [31:0] a, d;
    bq_t eq;
    bit  to;
    int  r0, c0;
    a = exp_addr1; d = $urandom;
    mem1[a] = d;
    eq = exp_update(a, d);
    r0 = rdn1; c0 = cap1.size();
    @(negedge clk) read1 = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL held_busy got %b want 1", busy1); end
    read1 = 1'b0;
    repeat (12) @(negedge clk);
    read1 = 1'b1;
    repeat (12) @(negedge clk);
    wait_idle(0, to);
    repeat (60) @(negedge clk);
    read1 = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL held_timeout got busy want idle"); end
    checks++; if (rdn1 - r0 != 1) begin errors++; $display("FAIL held_rdcnt got %0d want 1", rdn1 - r0); end
    checks++; if (cap1.size() - c0 != 18) begin errors++; $display("FAIL held_len got %0d want 18", cap1.size() - c0); end
    for (int i = 0; i < 18 && c0 + i < cap1.size(); i++) begin
      checks++;
      if (cap1[c0 + i] !== eq[i]) begin errors++; $display("FAIL held_byte[%0d] got %03h want %03h", i, cap1[c0 + i], eq[i]); end
    end
    exp_addr1 = exp_addr1 + 32'd4;
    checks++; if (addr1 !== exp_addr1 || busy1 !== 1'b0)
      begin errors++; $display("FAIL held_end got addr %h busy %b want %h 0", addr1, busy1, exp_addr1); end
  endtask

`ifdef LCD_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] a, d;
    bq_t eq;
    bit  to;
    int  r0, c0;
    r0 = rdn1; c0 = cap1.size();
    press(0, 5);
    repeat (40) @(negedge clk);
    checks++; if (rdn1 - r0 != 0 || cap1.size() != c0)
      begin errors++; $display("FAIL glitch got %0d reads want 0", rdn1 - r0); end
    a = exp_addr1; d = $urandom;
    mem1[a] = d;
    eq = exp_update(a, d);
    press(0, 12);
    wait_idle(0, to);
    checks++; if (to || rdn1 - r0 != 1) begin errors++; $display("FAIL debounce_press got %0d reads want 1", rdn1 - r0); end
    checks++; if (cap1.size() - c0 != 18) begin errors++; $display("FAIL debounce_len got %0d want 18", cap1.size() - c0); end
    for (int i = 0; i < 18 && c0 + i < cap1.size(); i++) begin
      checks++;
      if (cap1[c0 + i] !== eq[i]) begin errors++; $display("FAIL debounce_byte[%0d] got %03h want %03h", i, cap1[c0 + i], eq[i]); end
    end
    exp_addr1 = exp_addr1 + 32'd4;
  endtask
`endif

  task automatic test_reset_mid_line2();
    logic [8:0] exp_init [4];
    bit  to, reached;
    int  c0;
    exp_init = '{9'h038, 9'h00C, 9'h001, 9'h006};
    mem1[exp_addr1] = $urandom;
    c0 = cap1.size();
    press(0, 12);
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (cap1.size() - c0 >= 11) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin errors++; $display("FAIL midrst_reach got %0d bytes want 11", cap1.size() - c0); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (addr1 !== 32'h0 || lcd_data1 !== 8'h00) begin errors++; $display("FAIL midrst_addr_data got %h %h want 0 0", addr1, lcd_data1); end
    checks++; if ({rd1, on1, blon1, rw1, en1, rs1, busy1} !== 7'b0000001)
      begin errors++; $display("FAIL midrst_ctrl got %b want 0000001", {rd1, on1, blon1, rw1, en1, rs1, busy1}); end
    repeat (2) @(negedge clk);
    exp_addr1 = 32'h0;
    c0 = cap1.size();
    rst = 1'b1;
    wait_idle(0, to);
    checks++; if (to) begin errors++; $display("FAIL reinit_timeout got busy want idle"); end
    checks++; if (cap1.size() - c0 != 4) begin errors++; $display("FAIL reinit_len got %0d want 4", cap1.size() - c0); end
    for (int i = 0; i < 4 && c0 + i < cap1.size(); i++) begin
      checks++;
      if (cap1[c0 + i] !== exp_init[i]) begin errors++; $display("FAIL reinit_byte[%0d] got %03h want %03h", i, cap1[c0 + i], exp_init[i]); end
    end
    checks++; if (addr1 !== exp_addr1) begin errors++; $display("FAIL reinit_addr got %h want %h", addr1, exp_addr1); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_update_seq();
    test_wrap();
    test_held_key();
`ifdef LCD_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid_line2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
